// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: shared types and constants for the instruction-fetch sequencer.
//   fetch_state_t : sequencer states, encoded as BOOT=0, RUN=1, REDIRECT=2
//   PC_STEP       : sequential PC increment
//   NOP_INSN      : value the IF/ID register clears to on a flush
//   word_align()  : clears the byte-offset bits of an address
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    // Masking keeps every address bit in use, so no bit of the input dangles.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_bubble_cnt.sv
// fetch_bubble_cnt: 2-bit loadable down-counter that tracks the remaining
// post-redirect bubble cycles.
//   clk, reset  : clock and synchronous active-high reset
//   load_i      : load load_val_i (has priority over dec_i)
//   load_val_i  : value to load
//   dec_i       : decrement by one; saturates at zero
//   zero_o      : count is zero
module fetch_bubble_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [1:0] load_val_i,
    input  logic       dec_i,
    output logic       zero_o
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Next-count selection: load, decrement or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 2'd0)) begin
            cnt_d = cnt_q - 2'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 2'd0);

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns PC enable / next-PC, IF/ID
// write-enable and flush, ID/EX flush and the single IMEM port, which it
// shares between a boot loader (BOOT) and normal fetch (RUN / REDIRECT).
//   clk, reset        : clock, synchronous active-high reset
//   pc                : current PC
//   PCSel, ALUData    : taken branch/jump and its target from EX
//   hazard_stall      : load-use stall request from ID
//   ld_req/addr/data  : loader write request; ld_done ends the load
//   ld_ack            : loader write accepted this cycle
//   imem_addr/we/wdata: IMEM port
//   pc_we, pc_next    : PC register load enable and value
//   ifid_we/flush     : IF/ID control; idex_flush : ID/EX bubble insert
//   misalign          : registered pulse, taken target not word-aligned
//   state_dbg         : current state encoding
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC         = 32'h0000_0000,
    parameter bit          BOOT_EN          = 1'b1,
    parameter int          REDIRECT_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        PCSel,
    input  logic [31:0] ALUData,
    input  logic        hazard_stall,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    input  logic        ld_done,
    output logic        ld_ack,
    output logic [31:0] imem_addr,
    output logic        imem_we,
    output logic [31:0] imem_wdata,
    output logic        pc_we,
    output logic [31:0] pc_next,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        misalign,
    output logic [1:0]  state_dbg
);

    localparam bit           HAS_REDIRECT = (REDIRECT_BUBBLES > 0);
    localparam logic [1:0]   RELOAD_CNT   = HAS_REDIRECT ? 2'(REDIRECT_BUBBLES - 1) : 2'd0;
    localparam fetch_state_t RESET_STATE  = BOOT_EN ? BOOT : RUN;

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic         misalign_q;
    logic         misalign_d;
    logic         cnt_load_s;
    logic         cnt_dec_s;
    logic         cnt_zero_s;

    fetch_bubble_cnt u_bubble_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_s),
        .load_val_i (RELOAD_CNT),
        .dec_i      (cnt_dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Next-state and combinational control outputs. Reset forces the safe
    // output set; the state register itself is reset in the always_ff.
    always_comb begin
        state_d    = state_q;
        misalign_d = 1'b0;
        cnt_load_s = 1'b0;
        cnt_dec_s  = 1'b0;
        pc_we      = 1'b0;
        pc_next    = RESET_PC;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        imem_addr  = pc;
        imem_we    = 1'b0;
        imem_wdata = ld_data;
        ld_ack     = 1'b0;
        if (reset) begin
            // An in-flight loader write is dropped here.
            ifid_flush = 1'b1;
        end else begin
            case (state_q)
                BOOT: begin
                    imem_addr  = word_align(ld_addr);
                    imem_we    = ld_req;
                    ld_ack     = ld_req;
                    ifid_flush = 1'b1;
                    if (ld_done) begin
                        pc_we   = 1'b1;
                        pc_next = RESET_PC;
                        state_d = RUN;
                    end else begin
                        state_d = BOOT;
                    end
                end
                RUN, REDIRECT: begin
                    if (PCSel) begin
                        pc_we      = 1'b1;
                        pc_next    = word_align(ALUData);
                        ifid_we    = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        misalign_d = (ALUData[1:0] != 2'b00);
                        if (HAS_REDIRECT) begin
                            cnt_load_s = 1'b1;
                            state_d    = REDIRECT;
                        end else begin
                            state_d    = RUN;
                        end
                    end else if (hazard_stall && (state_q == RUN)) begin
                        // ID holds a bubble during REDIRECT, so stalls only apply in RUN.
                        idex_flush = 1'b1;
                    end else begin
                        pc_we   = 1'b1;
                        pc_next = pc + PC_STEP;
                        ifid_we = 1'b1;
                        if (state_q == REDIRECT) begin
                            ifid_flush = 1'b1;
                            if (cnt_zero_s) begin
                                state_d = RUN;
                            end else begin
                                cnt_dec_s = 1'b1;
                            end
                        end else begin
                            ifid_flush = 1'b0;
                        end
                    end
                end
                default: begin
                    // Unused encoding: recover to the post-reset state.
                    ifid_flush = 1'b1;
                    state_d    = RESET_STATE;
                end
            endcase
        end
    end

    // State and misalign registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RESET_STATE;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    assign misalign  = misalign_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: scoreboard bench for fetch_ctrl (BOOT_EN=1, REDIRECT_BUBBLES=2).
// Each cycle the expected outputs are pushed when the stimulus is driven and
// popped for comparison once the combinational outputs have settled.
module tb_fetch_ctrl;

    typedef struct {
        logic        pwe;
        logic [31:0] pn;
        logic        iwe;
        logic        ifl;
        logic        idf;
        logic        mwe;
        logic [31:0] ma;
        logic [31:0] wd;
        logic [1:0]  st;
        logic        mis;
        logic        vld;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        PCSel;
    logic [31:0] ALUData;
    logic        hazard_stall;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        ld_ack;
    logic [31:0] imem_addr;
    logic        imem_we;
    logic [31:0] imem_wdata;
    logic        pc_we;
    logic [31:0] pc_next;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_flush;
    logic        misalign;
    logic [1:0]  state_dbg;

    int   total;
    int   bad;
    exp_t exp_q[$];
    logic [31:0] imem [0:15];

    fetch_ctrl #(
        .RESET_PC         (32'h0000_0000),
        .BOOT_EN          (1'b1),
        .REDIRECT_BUBBLES (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .PCSel        (PCSel),
        .ALUData      (ALUData),
        .hazard_stall (hazard_stall),
        .ld_req       (ld_req),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .ld_done      (ld_done),
        .ld_ack       (ld_ack),
        .imem_addr    (imem_addr),
        .imem_we      (imem_we),
        .imem_wdata   (imem_wdata),
        .pc_we        (pc_we),
        .pc_next      (pc_next),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .misalign     (misalign),
        .state_dbg    (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural IMEM fed by the DUT write port.
    always @(posedge clk) begin
        if (imem_we) imem[imem_addr[5:2]] <= imem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic exp_t mk(input logic pwe, input logic [31:0] pn, input logic iwe,
                                input logic ifl, input logic idf, input logic mwe,
                                input logic [31:0] ma, input logic [31:0] wd,
                                input logic [1:0] st, input logic mis, input logic vld);
        exp_t e;
        e.pwe = pwe; e.pn = pn; e.iwe = iwe; e.ifl = ifl; e.idf = idf;
        e.mwe = mwe; e.ma = ma; e.wd = wd; e.st = st; e.mis = mis; e.vld = vld;
        return e;
    endfunction

    // One cycle: drive, push expectation, settle, pop and compare, advance.
    task automatic cyc(input logic rst, input logic [31:0] pcv, input logic psel,
                       input logic [31:0] alu, input logic hz, input logic lreq,
                       input logic [31:0] laddr, input logic [31:0] ldat,
                       input logic ldone, input exp_t e);
        exp_t x;
        reset = rst; pc = pcv; PCSel = psel; ALUData = alu; hazard_stall = hz;
        ld_req = lreq; ld_addr = laddr; ld_data = ldat; ld_done = ldone;
        exp_q.push_back(e);
        #2;
        x = exp_q.pop_front();
        chk("pc_we", {31'd0, pc_we}, {31'd0, x.pwe});
        if (x.pwe) chk("pc_next", pc_next, x.pn);
        chk("ifid_we", {31'd0, ifid_we}, {31'd0, x.iwe});
        chk("ifid_flush", {31'd0, ifid_flush}, {31'd0, x.ifl});
        chk("idex_flush", {31'd0, idex_flush}, {31'd0, x.idf});
        chk("imem_we", {31'd0, imem_we}, {31'd0, x.mwe});
        chk("ld_ack", {31'd0, ld_ack}, {31'd0, x.mwe});
        chk("imem_addr", imem_addr, x.ma);
        if (x.mwe) chk("imem_wdata", imem_wdata, x.wd);
        if (x.vld) begin
            chk("state_dbg", {30'd0, state_dbg}, {30'd0, x.st});
            chk("misalign", {31'd0, misalign}, {31'd0, x.mis});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 16; i++) imem[i] = 32'd0;
        reset = 1'b1; pc = 32'd0; PCSel = 1'b0; ALUData = 32'd0; hazard_stall = 1'b0;
        ld_req = 1'b0; ld_addr = 32'd0; ld_data = 32'd0; ld_done = 1'b0;
        @(posedge clk);
        #1;
        // Reset, two cycles (state only defined after the first edge).
        cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0));
        cyc(1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1));
        // Boot writes; PCSel/hazard ignored, last address has offset bits set.
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 32'h13, 1'b0,
            mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h13, 2'd0, 1'b0, 1'b1));
        cyc(1'b0, 32'h0, 1'b1, 32'h102, 1'b1, 1'b1, 32'h4, 32'h93, 1'b0,
            mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h93, 2'd0, 1'b0, 1'b1));
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hB, 32'h113, 1'b0,
            mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8, 32'h113, 2'd0, 1'b0, 1'b1));
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1,
            mk(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1));
        // Sequential fetch; a loader request in RUN gets no ack.
        cyc(1'b0, 32'h0FFC, 1'b0, 32'h0, 1'b0, 1'b1, 32'h30, 32'hDEAD, 1'b0,
            mk(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0FFC, 32'h0, 2'd1, 1'b0, 1'b1));
        cyc(1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 2'd1, 1'b0, 1'b1));
        // Load-use stall for two cycles, then resume.
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 32'h20, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0,
                mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 2'd1, 1'b0, 1'b1));
        end
        cyc(1'b0, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 2'd1, 1'b0, 1'b1));
        // Redirect beats stall, then two bubble cycles (stall ignored), then RUN.
        cyc(1'b0, 32'h24, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 2'd1, 1'b0, 1'b1));
        cyc(1'b0, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b1));
        cyc(1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h108, 1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 1'b1));
        cyc(1'b0, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 32'h0, 2'd1, 1'b0, 1'b1));
        // Misaligned target: aligned pc_next, misalign for exactly one cycle.
        cyc(1'b0, 32'h10C, 1'b1, 32'h102, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h0, 2'd1, 1'b0, 1'b1));
        cyc(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h104, 1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 2'd2, 1'b1, 1'b1));
        cyc(1'b0, 32'h104, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h108, 1'b1, 1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 1'b1));
        cyc(1'b0, 32'h108, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h108, 32'h0, 2'd1, 1'b0, 1'b1));
        // Redirect, then reset while counter=1 with a loader write that must drop.
        cyc(1'b0, 32'h10C, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h200, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10C, 32'h0, 2'd1, 1'b0, 1'b1));
        cyc(1'b1, 32'h200, 1'b0, 32'h0, 1'b0, 1'b1, 32'hC, 32'hBAD, 1'b0,
            mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 1'b1));
        cyc(1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1));
        cyc(1'b0, 32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1,
            mk(1'b1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1));
        cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
            mk(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b1));
        // Loaded image, and no stray writes.
        chk("imem0", imem[0], 32'h13);
        chk("imem1", imem[1], 32'h93);
        chk("imem2", imem[2], 32'h113);
        chk("imem3", imem[3], 32'h0);
        chk("imem12", imem[12], 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage: owns PC update enable and next-PC selection, IF/ID write-enable and flush, and the single IMEM port.
- Arbitrates the IMEM port between a boot loader (writes program image after reset) and normal fetch.
- Applies load-use stalls and taken-branch redirects, with a configurable number of post-redirect bubbles for registered-read IMEM variants.
- Sits between the hazard unit / EX branch resolution and the PC register, PC adder path, IMEM and IF/ID register.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after boot.
- BOOT_EN, 1, 1 means reset enters BOOT (loader owns IMEM); 0 means reset enters RUN directly.
- REDIRECT_BUBBLES, 1, extra flush cycles after a redirect, range 0..3; 0 means no REDIRECT state.

Ports:
- clk  in  1  rising-edge clock, the single clock.
- reset  in  1  synchronous, active-high.
- pc  in  32  current PC from the PC register.
- PCSel  in  1  taken branch/jump from EX.
- ALUData  in  32  branch/jump target from EX.
- hazard_stall  in  1  load-use stall request from ID.
- ld_req  in  1  loader write request.
- ld_addr  in  32  loader word address (byte address, low 2 bits ignored).
- ld_data  in  32  loader write data.
- ld_done  in  1  loader finished; one-cycle pulse.
- ld_ack  out  1  loader write accepted this cycle.
- imem_addr  out  32  IMEM address.
- imem_we  out  1  IMEM write enable.
- imem_wdata  out  32  IMEM write data.
- pc_we  out  1  PC register load enable.
- pc_next  out  32  value loaded into PC when pc_we=1.
- ifid_we  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clears to NOP (32'h0000_0013) and PC 0 at next edge.
- idex_flush  out  1  ID/EX clears to bubble at next edge.
- misalign  out  1  registered one-cycle pulse: taken target had ALUData[1:0]!=0.
- state_dbg  out  2  encoded state (BOOT=0, RUN=1, REDIRECT=2).

Behaviour:
- Outputs are combinational from state, counter and inputs, except misalign (registered).
- While reset=1: pc_we=0, ifid_we=0, ifid_flush=1, idex_flush=0, imem_we=0, ld_ack=0, pc_next=RESET_PC, imem_addr=pc.
- After reset: state=BOOT if BOOT_EN else RUN; counter=0; misalign=0.
- BOOT:
  - imem_addr={ld_addr[31:2],2'b00}, imem_wdata=ld_data.
  - imem_we=ld_ack=ld_req. Writes are single-cycle, accepted every cycle ld_req=1.
  - pc_we=0, ifid_we=0, ifid_flush=1. PCSel and hazard_stall are ignored.
  - ld_done=1 → RUN next cycle, and pc_we=1 with pc_next=RESET_PC in that same cycle. If ld_req=1 in the same cycle, the write still completes.
- RUN:
  - imem_addr=pc, imem_we=0, ld_ack=0. ld_req is ignored (no ack, loader must not hang on it).
  - Priority is PCSel > hazard_stall > normal.
  - PCSel=1: pc_we=1, pc_next={ALUData[31:2],2'b00}, ifid_flush=1, idex_flush=1, ifid_we=1. If REDIRECT_BUBBLES>0, go to REDIRECT with counter=REDIRECT_BUBBLES-1. misalign pulses next cycle if ALUData[1:0]!=0.
  - hazard_stall=1 (PCSel=0): pc_we=0, ifid_we=0, idex_flush=1, ifid_flush=0.
  - Normal: pc_we=1, pc_next=pc+32'd4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), ifid_we=1, flushes 0.
- REDIRECT:
  - PC advances as in normal RUN, with ifid_flush=1 and idex_flush=0.
  - hazard_stall is ignored (ID holds a bubble).
  - counter==0 → RUN, else counter decrements.
  - PCSel=1 here is handled exactly as in RUN and reloads the counter.
- Latency: redirect target is fetched the cycle after PCSel. First valid IF/ID entry after a redirect appears REDIRECT_BUBBLES+1 edges later.
- Reset mid-operation (any state) returns to the post-reset state at the next edge. An in-flight loader write in that cycle is dropped (imem_we=0).

Decomposition:
- Package fetch_ctrl_pkg holds:
  - state enum fetch_state_t {BOOT, RUN, REDIRECT}.
  - constants PC_STEP=32'd4 and NOP_INSN=32'h0000_0013.
- One sub-module, fetch_bubble_cnt: 2-bit loadable down-counter (load, dec, zero flag).
- The existing PC register gains an enable input. The PC mux is replaced by pc_next.

Test Plan:
- Boot load: BOOT_EN=1, reset 2 cycles, then 3 ld_req writes to 0x0/0x4/0x8 with data 0x13/0x93/0x113, then ld_done → imem_we/ld_ack high 3 cycles, IMEM words match, pc_we=1 with pc_next=0 in the ld_done cycle, state_dbg=1 afterward.
- Sequential fetch: RUN, pc=0x0FFC → pc_next=0x1000, ifid_we=1. pc=0xFFFF_FFFC → pc_next=0x0.
- Stall: hazard_stall high 2 cycles at pc=0x20 → pc_we=0, ifid_we=0, idex_flush=1 both cycles; fetch resumes with pc_next=0x24.
- Redirect priority: PCSel=1, ALUData=0x100 with hazard_stall=1 → pc_next=0x100, ifid_flush=1, idex_flush=1. REDIRECT_BUBBLES=2 gives two further ifid_flush cycles, then RUN.
- Misaligned target: PCSel=1, ALUData=0x102 → pc_next=0x100, misalign=1 for exactly one cycle after.
- Reset in REDIRECT: assert reset with counter=1 → next edge state=BOOT, pc_we=0, ifid_flush=1, no imem_we.
